// File: rtl/counter_pkg.sv
// ============================================================================
// Module : counter_pkg
// Brief  : Shared digit/radix types and helpers for the multi-channel counter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package counter_pkg;

    typedef logic [3:0] digit_t;

    typedef enum logic {
        RADIX_DEC = 1'b0,
        RADIX_HEX = 1'b1
    } radix_e;

    localparam int c_MAX_CH = 8;

    function automatic digit_t radix_max(input radix_e r);
        return (r == RADIX_HEX) ? 4'd15 : 4'd9;
    endfunction

    function automatic radix_e radix_of(input logic [c_MAX_CH-1:0] mask, input int c);
        if (c < 0 || c >= c_MAX_CH) begin
            return RADIX_DEC;
        end
        return mask[c[2:0]] ? RADIX_HEX : RADIX_DEC;
    endfunction

endpackage

`default_nettype wire

// File: rtl/counter_digit.sv
// ============================================================================
// Module : counter_digit
// Brief  : One radix-10/16 digit with carry (and, with CNT_DOWN_EN, borrow).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module counter_digit
    import counter_pkg::*;
#(
    parameter radix_e RADIX = RADIX_DEC
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_clr,
    input  logic   i_hold,
    input  logic   i_cin,
`ifdef CNT_DOWN_EN
    input  logic   i_bin,
    output logic   o_bout,
`endif
    output digit_t o_digit,
    output logic   o_cout
);

    localparam digit_t c_MAX = radix_max(RADIX);

    digit_t r_digit;
    logic   w_at_max;
    logic   w_at_zero;

    // >= keeps a decimal digit inside 0..9 even from an unexpected state
    assign w_at_max  = (r_digit >= c_MAX);
    assign w_at_zero = (r_digit == 4'd0);
    assign o_cout    = i_cin & w_at_max;
    assign o_digit   = r_digit;

`ifdef CNT_DOWN_EN
    assign o_bout = i_bin & w_at_zero;
`endif

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_digit <= 4'd0;
        end else if (i_hold) begin
            r_digit <= r_digit;
        end else if (i_cin) begin
            r_digit <= w_at_max ? 4'd0 : r_digit + 4'd1;
`ifdef CNT_DOWN_EN
        end else if (i_bin) begin
            r_digit <= w_at_zero ? c_MAX : r_digit - 4'd1;
`endif
        end
    end

endmodule

`default_nettype wire

// File: rtl/multi_channel_digit_counter.sv
// ============================================================================
// Module : multi_channel_digit_counter
// Brief  : N independent multi-digit DEC/HEX event counters with sticky
//          overflow; optional down-counting when CNT_DOWN_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module multi_channel_digit_counter
    import counter_pkg::*;
#(
    parameter int                NUM_CH     = 2,
    parameter int                NUM_DIGITS = 4,
    parameter logic [NUM_CH-1:0] HEX_MASK   = 'b01,
    parameter int                WRAP       = 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_CH-1:0]                      inc,
`ifdef CNT_DOWN_EN
    input  logic [NUM_CH-1:0]                      dec,
`endif
    input  logic [NUM_CH-1:0]                      clr,
    output logic [NUM_CH-1:0][NUM_DIGITS-1:0][3:0] encoded,
    output logic [NUM_CH-1:0][NUM_DIGITS-1:0]      digit_point,
    output logic [NUM_CH-1:0]                      ovf,
    output logic [NUM_CH-1:0]                      zero
);

    localparam logic                c_WRAP      = (WRAP != 0);
    localparam logic [c_MAX_CH-1:0] c_HEX_MASK8 = c_MAX_CH'(HEX_MASK);

    logic [NUM_CH-1:0] w_dec;

`ifdef CNT_DOWN_EN
    assign w_dec = dec;
`else
    assign w_dec = '0;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [NUM_DIGITS:0]   w_carry;
        logic                  w_inc_ev;
        logic                  w_wrap_ev;
        logic                  w_hold;
        logic                  r_ovf;
        logic [NUM_DIGITS-1:0] w_dp;

        // simultaneous inc and dec cancel out
        assign w_inc_ev   = inc[c] & ~w_dec[c];
        assign w_carry[0] = w_inc_ev;

`ifdef CNT_DOWN_EN
        logic [NUM_DIGITS:0] w_borrow;
        logic                w_dec_ev;

        assign w_dec_ev    = w_dec[c] & ~inc[c];
        assign w_borrow[0] = w_dec_ev;
        assign w_wrap_ev   = w_carry[NUM_DIGITS] | w_borrow[NUM_DIGITS];
`else
        assign w_wrap_ev   = w_carry[NUM_DIGITS];
`endif

        // carry/borrow out of the MSD means full-scale crossing; saturate mode freezes all digits
        assign w_hold = ~c_WRAP & w_wrap_ev;

        for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
            counter_digit #(
                .RADIX (radix_of(c_HEX_MASK8, c))
            ) u_digit (
                .clk     (clk),
                .rst     (reset),
                .i_clr   (clr[c]),
                .i_hold  (w_hold),
                .i_cin   (w_carry[d]),
`ifdef CNT_DOWN_EN
                .i_bin   (w_borrow[d]),
                .o_bout  (w_borrow[d+1]),
`endif
                .o_digit (encoded[c][d]),
                .o_cout  (w_carry[d+1])
            );
        end

        always_ff @(posedge clk) begin
            if (reset || clr[c]) begin
                r_ovf <= 1'b0;
            end else if (w_wrap_ev) begin
                r_ovf <= 1'b1;
            end
        end

        always_comb begin
            w_dp             = '0;
            w_dp[NUM_DIGITS-1] = r_ovf;
        end

        assign ovf[c]         = r_ovf;
        assign digit_point[c] = w_dp;
        assign zero[c]        = (encoded[c] == '0);
    end

endmodule

`default_nettype wire

// File: tb/tb_multi_channel_digit_counter.sv
// ============================================================================
// Module : tb_multi_channel_digit_counter
// Brief  : Randomised and directed bench for the wrap and saturate builds,
//          checked against an integer-value reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_multi_channel_digit_counter;

    localparam int              NCH   = 2;
    localparam int              ND    = 4;
    localparam logic [NCH-1:0]  HMASK = 2'b10;
`ifdef CNT_DOWN_EN
    localparam bit DOWN = 1'b1;
`else
    localparam bit DOWN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [NCH-1:0] inc = '0;
    logic [NCH-1:0] dec = '0;
    logic [NCH-1:0] clr = '0;

    logic [NCH-1:0][ND-1:0][3:0] enc  [2];
    logic [NCH-1:0][ND-1:0]      dp   [2];
    logic [NCH-1:0]              ovf  [2];
    logic [NCH-1:0]              zero [2];

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    multi_channel_digit_counter #(
        .NUM_CH(NCH), .NUM_DIGITS(ND), .HEX_MASK(HMASK), .WRAP(1)
    ) dut_w (
        .clk(clk), .reset(reset), .inc(inc),
`ifdef CNT_DOWN_EN
        .dec(dec),
`endif
        .clr(clr), .encoded(enc[0]), .digit_point(dp[0]), .ovf(ovf[0]), .zero(zero[0])
    );

    multi_channel_digit_counter #(
        .NUM_CH(NCH), .NUM_DIGITS(ND), .HEX_MASK(HMASK), .WRAP(0)
    ) dut_s (
        .clk(clk), .reset(reset), .inc(inc),
`ifdef CNT_DOWN_EN
        .dec(dec),
`endif
        .clr(clr), .encoded(enc[1]), .digit_point(dp[1]), .ovf(ovf[1]), .zero(zero[1])
    );

    // ---------------- reference model: plain integer counts ----------------
    int m_val [2][NCH];
    bit m_ovf [2][NCH];

    function automatic int radix(input int c);
        return HMASK[c] ? 16 : 10;
    endfunction

    function automatic int full(input int c);
        int p = 1;
        for (int d = 0; d < ND; d++) p = p * radix(c);
        return p - 1;
    endfunction

    function automatic int mnext(input int v, input int fs, input bit wrap,
                                 input bit i, input bit d, input bit c);
        if (c) return 0;
        if (i && !d) return (v == fs) ? (wrap ? 0 : fs) : v + 1;
        if (d && !i) return (v == 0) ? (wrap ? fs : 0) : v - 1;
        return v;
    endfunction

    function automatic bit onext(input bit o, input int v, input int fs,
                                 input bit i, input bit d, input bit c);
        if (c) return 1'b0;
        if (i && !d && v == fs) return 1'b1;
        if (d && !i && v == 0) return 1'b1;
        return o;
    endfunction

    function automatic logic [ND*4-1:0] to_digits(input int v, input int r);
        logic [ND*4-1:0] res = '0;
        int p = 1;
        for (int d = 0; d < ND; d++) begin
            res[d*4 +: 4] = 4'((v / p) % r);
            p = p * r;
        end
        return res;
    endfunction

    initial begin
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < NCH; c++) begin
                m_val[k][c] = 0;
                m_ovf[k][c] = 1'b0;
            end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < NCH; c++) begin
                if (reset) begin
                    m_val[k][c] <= 0;
                    m_ovf[k][c] <= 1'b0;
                end else begin
                    m_val[k][c] <= mnext(m_val[k][c], full(c), (k == 0), inc[c], dec[c], clr[c]);
                    m_ovf[k][c] <= onext(m_ovf[k][c], m_val[k][c], full(c), inc[c], dec[c], clr[c]);
                end
            end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++)
                for (int c = 0; c < NCH; c++) begin
                    logic [ND-1:0] edp;
                    edp = '0;
                    edp[ND-1] = m_ovf[k][c];
                    chk($sformatf("enc dut%0d ch%0d", k, c), 64'(enc[k][c]),
                        64'(to_digits(m_val[k][c], radix(c))));
                    chk($sformatf("ovf dut%0d ch%0d", k, c), 64'(ovf[k][c]), 64'(m_ovf[k][c]));
                    chk($sformatf("zero dut%0d ch%0d", k, c), 64'(zero[k][c]), 64'(m_val[k][c] == 0));
                    chk($sformatf("dp dut%0d ch%0d", k, c), 64'(dp[k][c]), 64'(edp));
                end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic [NCH-1:0] i, input logic [NCH-1:0] d,
                       input logic [NCH-1:0] c, input logic r);
        inc   = i;
        dec   = DOWN ? d : '0;
        clr   = c;
        reset = r;
        @(posedge clk);
        #1;
        inc   = '0;
        dec   = '0;
        clr   = '0;
        reset = 1'b0;
    endtask

    initial begin
        cyc('0, '0, '0, 1'b1);
        cyc('0, '0, '0, 1'b1);
        chk_en = 1'b1;
        chk("reset enc", 64'(enc[0]), 64'd0);
        chk("reset zero", 64'(zero[0]), 64'(2'b11));
        chk("reset ovf", 64'(ovf[0]), 64'd0);
        chk("reset dp", 64'(dp[0]), 64'd0);

        for (int n = 0; n < 10; n++) cyc(2'b01, '0, '0, 1'b0);
        chk("dec ten", 64'(enc[0][0]), 64'h0010);
        chk("dec ten ovf", 64'(ovf[0][0]), 64'd0);
        chk("dec ten zero", 64'(zero[0][0]), 64'd0);

        for (int n = 0; n < 255; n++) cyc(2'b10, '0, '0, 1'b0);
        chk("hex ff", 64'(enc[0][1]), 64'h00FF);
        cyc(2'b10, '0, '0, 1'b0);
        chk("hex 100", 64'(enc[0][1]), 64'h0100);

        cyc('0, '0, 2'b01, 1'b0);
        for (int n = 0; n < 9999; n++) cyc(2'b01, '0, '0, 1'b0);
        chk("fs wrap dut", 64'(enc[0][0]), 64'h9999);
        chk("fs sat dut", 64'(enc[1][0]), 64'h9999);
        cyc(2'b01, '0, '0, 1'b0);
        chk("wrap enc", 64'(enc[0][0]), 64'h0000);
        chk("wrap ovf", 64'(ovf[0][0]), 64'd1);
        chk("wrap msd dp", 64'(dp[0][0][ND-1]), 64'd1);
        chk("sat enc", 64'(enc[1][0]), 64'h9999);
        chk("sat ovf", 64'(ovf[1][0]), 64'd1);

        cyc('0, '0, 2'b01, 1'b0);
        for (int n = 0; n < 5; n++) cyc(2'b01, '0, '0, 1'b0);
        chk("five", 64'(enc[0][0]), 64'h0005);
        cyc(2'b01, '0, 2'b01, 1'b0);
        chk("inc+clr enc", 64'(enc[0][0]), 64'h0000);
        chk("inc+clr ovf", 64'(ovf[1][0]), 64'd0);

`ifdef CNT_DOWN_EN
        for (int n = 0; n < 3; n++) cyc(2'b01, '0, '0, 1'b0);
        cyc(2'b01, 2'b01, '0, 1'b0);
        chk("inc+dec hold", 64'(enc[0][0]), 64'h0003);
        cyc('0, '0, 2'b01, 1'b0);
        for (int n = 0; n < 100; n++) cyc(2'b01, '0, '0, 1'b0);
        cyc('0, 2'b01, '0, 1'b0);
        chk("borrow 99", 64'(enc[0][0]), 64'h0099);
        cyc('0, '0, 2'b01, 1'b0);
        cyc('0, 2'b01, '0, 1'b0);
        chk("underflow wrap", 64'(enc[0][0]), 64'h9999);
        chk("underflow ovf", 64'(ovf[0][0]), 64'd1);
        chk("underflow sat", 64'(enc[1][0]), 64'h0000);
`endif

        for (int n = 0; n < 4; n++) cyc(2'b11, '0, '0, 1'b0);
        cyc(2'b11, '0, '0, 1'b1);
        chk("mid reset enc", 64'(enc[0]), 64'd0);
        chk("mid reset zero", 64'(zero[0]), 64'(2'b11));
        cyc(2'b11, '0, '0, 1'b0);
        chk("resume ch0", 64'(enc[0][0]), 64'h0001);
        chk("resume ch1", 64'(enc[0][1]), 64'h0001);

        for (int n = 0; n < 4000; n++) begin
            logic [NCH-1:0] ri, rd, rc;
            logic           rr;
            ri = NCH'($urandom);
            rd = NCH'($urandom);
            rc = '0;
            for (int c = 0; c < NCH; c++) rc[c] = ($urandom_range(0, 31) == 0);
            rr = ($urandom_range(0, 499) == 0);
            cyc(ri, rd, rc, rr);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multi_channel_digit_counter.md
# multi_channel_digit_counter

Parametrised N-channel event counter that generalises the paired HEX/DEC button-press counters feeding the seven-segment drivers. Each channel counts single-cycle event pulses (debouncer `button_down` outputs) in its own radix, with configurable digit count, wrap or saturate at full scale, synchronous clear, and a sticky overflow flag. Outputs are per-digit 4-bit codes and digit points that connect directly to `seven_segment` / `seven_segment_pmod` `encoded` / `digit_point` inputs.

## Interface
- `NUM_CH`, 2, number of independent counter channels (1..8)
- `NUM_DIGITS`, 4, digits per channel (1..8)
- `HEX_MASK`, `'b01`, `NUM_CH` bits; bit c = 1 gives channel c radix 16, 0 gives radix 10
- `WRAP`, 1, 1: wrap to zero past full scale; 0: saturate at full scale
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high; one clock; all state cleared on the rising edge of `clk` while high
- `inc`  in  `[NUM_CH]`  increment pulse, one per channel
- `dec`  in  `[NUM_CH]`  decrement pulse (present only with `CNT_DOWN_EN`)
- `clr`  in  `[NUM_CH]`  synchronous channel clear
- `encoded`  out  `[NUM_CH][NUM_DIGITS-1:0][3:0]`  digit values; index 0 is least significant
- `digit_point`  out  `[NUM_CH][NUM_DIGITS-1:0]`  decimal-point enables
- `ovf`  out  `[NUM_CH]`  sticky overflow/underflow flag
- `zero`  out  `[NUM_CH]`  count equals zero

## Operation
- Per channel, priority each cycle: `clr` > (`inc` XOR `dec`) > hold. If `inc` and `dec` are both high, the channel holds.
- Increment: ripple carry from digit 0 upward. A digit at radix-1 becomes 0 and carries. In decimal channels, digits never exceed 9.
- Full scale: every digit equals radix-1, e.g. 9999 for DEC or FFFF for HEX with 4 digits.
- Increment at full scale:
  - `WRAP`=1: count becomes 0 and `ovf` sets.
  - `WRAP`=0: count holds and `ovf` sets.
- Decrement at zero:
  - `WRAP`=1: count becomes full scale and `ovf` sets.
  - `WRAP`=0: count holds at 0 and `ovf` sets.
- `ovf` stays set until `clr` or `reset` for that channel.
- `digit_point[c][NUM_DIGITS-1]` = `ovf[c]`. All other digit points are 0.
- `zero[c]` is combinational from the registered count.
- Reset values: `encoded` all 0, `ovf` 0, `digit_point` 0, `zero` all 1.
- Channels are fully independent. Events on one channel never affect another.

## Timing
- An `inc`/`dec`/`clr` sampled high at edge N updates `encoded` and `ovf` after edge N, visible in cycle N+1. Latency is 1 clock; there are no wait states.
- Inputs are expected as single-cycle pulses. A level held high for k cycles counts k events. Consecutive-cycle pulses are all counted; the maximum rate is one event per clock.
- `reset` asserted mid-count clears the state at the next edge and overrides `clr`/`inc`/`dec` in that cycle.
- The full digit carry chain resolves in one cycle. The critical path is `NUM_DIGITS` digit stages.

## Configuration
- `CNT_DOWN_EN` defined:
  - The `dec` port exists.
  - Decrement uses ripple borrow: a digit at 0 becomes radix-1 and borrows.
  - The underflow rules above apply.
- `CNT_DOWN_EN` undefined:
  - The `dec` port is absent and treated as 0.
  - The block is increment-only, and no borrow logic is synthesised.

## Structure
- Package `counter_pkg` holds:
  - `typedef logic [3:0] digit_t`
  - `typedef enum logic {RADIX_DEC, RADIX_HEX} radix_e`
  - functions `radix_max(radix_e)` (returns 9 or 15) and `radix_of(HEX_MASK, c)`
- Sub-module `counter_digit` implements one digit register with radix, carry/borrow in, carry/borrow out, clear, wrap, and hold. It is instantiated `NUM_CH`×`NUM_DIGITS` times inside generate loops.
- Per-channel overflow and zero logic sits in the top module.

## Test plan
- Reset, then 10 `inc` pulses on DEC channel 0 → `encoded[0]` = 0,0,1,0 (value 10); `ovf[0]`=0; `zero[0]`=0.
- HEX channel 1, 255 back-to-back `inc` pulses → `encoded[1]` = 00FF; one more pulse → 0100 on the next cycle.
- `WRAP`=1, DEC channel 0 loaded to 9999 via increments, then one `inc` → 0000, `ovf[0]`=1, MSD `digit_point`=1. With `WRAP`=0, the same stimulus → 9999 and `ovf[0]`=1.
- `inc` and `clr` asserted in the same cycle on a count of 5 → 0000 and `ovf` cleared. `inc` and `dec` in the same cycle (`CNT_DOWN_EN`) → count unchanged.
- `CNT_DOWN_EN`, DEC channel at 0100, one `dec` → 0099. At 0000, one `dec` → 9999 (`WRAP`=1) with `ovf`=1.
- `reset` asserted for one cycle while `inc` pulses stream on both channels → all `encoded`=0 and `zero`=all 1 in the cycle after reset; counting resumes from 1 on the next pulse.
